// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 512 Hz event source, 8-step length/sweep/envelope strobes, trigger qualification.
// Latency: strobes and start are registered, 1 clk after evt/trigger. No backpressure; strobes are 1-clk pulses.
// Optional SOUND_EXT_DIV_EN: evt taken from the synchronised falling edge of div_bit instead of the prescaler.
module sound_frame_seq #(
    parameter int CLK_DIV   = 8192,
    parameter int DIV_WIDTH = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apu_on,
    input  logic [3:0] trig_wr,
    input  logic [3:0] dac_en,
    input  logic       div_bit,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_envelope,
    output logic [3:0] start,
    output logic [2:0] step,
    output logic       len_next_skip
);

    logic evt;

`ifdef SOUND_EXT_DIV_EN
    logic [1:0] div_sync;
    logic       div_prev;

    // History is held at 0 while powered down so power-up never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_sync <= 2'b00;
            div_prev <= 1'b0;
        end else if (!apu_on) begin
            div_sync <= 2'b00;
            div_prev <= 1'b0;
        end else begin
            div_sync <= {div_sync[0], div_bit};
            div_prev <= div_sync[1];
        end
    end

    assign evt = apu_on & div_prev & ~div_sync[1];
`else
    localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] presc;
    logic                 unused_div;

    assign unused_div = div_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (!apu_on || evt) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign evt = apu_on && (presc == PRESC_LAST);
`endif

    // Strobes default low every cycle, so each one is exactly a single clk wide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step           <= 3'd0;
            clk_length_ctr <= 1'b0;
            clk_sweep      <= 1'b0;
            clk_envelope   <= 1'b0;
            start          <= 4'b0000;
        end else begin
            clk_length_ctr <= 1'b0;
            clk_sweep      <= 1'b0;
            clk_envelope   <= 1'b0;
            start          <= apu_on ? (trig_wr & dac_en) : 4'b0000;
            if (!apu_on) begin
                step <= 3'd0;
            end else if (evt) begin
                clk_length_ctr <= ~step[0];
                clk_sweep      <= (step[1:0] == 2'b10);
                clk_envelope   <= (step == 3'd7);
                step           <= step + 3'd1;
            end
        end
    end

    assign len_next_skip = step[0];

endmodule

// File: tb/tb_sound_frame_seq.sv
// Bench for sound_frame_seq with a short prescaler; expected outputs come from closed-form timing of the step table.
module tb_sound_frame_seq;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       apu_on;
    logic [3:0] trig_wr;
    logic [3:0] dac_en;
    logic       div_bit;
    logic       clk_length_ctr;
    logic       clk_sweep;
    logic       clk_envelope;
    logic [3:0] start;
    logic [2:0] step;
    logic       len_next_skip;

    int total = 0;
    int bad   = 0;
    int j     = 0;
    int n_len, n_sw, n_env;

    sound_frame_seq #(.CLK_DIV(D), .DIV_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .apu_on(apu_on), .trig_wr(trig_wr), .dac_en(dac_en),
        .div_bit(div_bit), .clk_length_ctr(clk_length_ctr), .clk_sweep(clk_sweep),
        .clk_envelope(clk_envelope), .start(start), .step(step), .len_next_skip(len_next_skip)
    );

    always #5 clk = ~clk;

    // j = cycles since power-on; strobes appear in cycles j = k*D (k>=1) executing step (k-1) mod 8.
    task automatic run_check(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            bit         was_on;
            logic [3:0] e_start;
            logic [2:0] e_step;
            logic [2:0] e_strb;
            int         s;
            was_on  = apu_on;
            e_start = was_on ? (trig_wr & dac_en) : 4'b0000;
            @(posedge clk);
            #1;
            j      = was_on ? j + 1 : 0;
            e_strb = 3'b000;
            if (j > 0 && (j % D) == 0) begin
                s = (j / D - 1) % 8;
                e_strb = {s % 2 == 0, s == 2 || s == 6, s == 7};
            end
            e_step = 3'((j / D) % 8);
            total++;
            if ({clk_length_ctr, clk_sweep, clk_envelope} !== e_strb) begin
                bad++;
                $display("FAIL strobes j=%0d got=%b exp=%b", j, {clk_length_ctr, clk_sweep, clk_envelope}, e_strb);
            end
            total++;
            if (step !== e_step) begin
                bad++;
                $display("FAIL step j=%0d got=%0d exp=%0d", j, step, e_step);
            end
            total++;
            if (len_next_skip !== e_step[0]) begin
                bad++;
                $display("FAIL len_next_skip j=%0d got=%b exp=%b", j, len_next_skip, e_step[0]);
            end
            total++;
            if (start !== e_start) begin
                bad++;
                $display("FAIL start j=%0d got=%b exp=%b", j, start, e_start);
            end
            n_len += int'(clk_length_ctr);
            n_sw  += int'(clk_sweep);
            n_env += int'(clk_envelope);
            if (rnd) begin
                trig_wr = 4'($urandom);
                dac_en  = 4'($urandom);
            end
        end
    endtask

    task automatic clear_counts();
        n_len = 0;
        n_sw  = 0;
        n_env = 0;
    endtask

    task automatic power_cycle();
        trig_wr = 4'b0000;
        apu_on  = 1'b0;
        run_check(3, 1'b0);
        apu_on = 1'b1;
        clear_counts();
    endtask

    task automatic test_reset();
        rst = 1'b0; apu_on = 1'b0; trig_wr = 4'b0000; dac_en = 4'b0000; div_bit = 1'b0;
        #23;
        total++;
        if ({clk_length_ctr, clk_sweep, clk_envelope, start, step, len_next_skip} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state got=%b exp=0", {clk_length_ctr, clk_sweep, clk_envelope, start, step, len_next_skip});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        j = 0;
    endtask

    task automatic test_power_up();
        apu_on = 1'b1;
        clear_counts();
        run_check(8 * D, 1'b0);
        total++;
        if (n_len != 4 || n_sw != 2 || n_env != 1) begin
            bad++;
            $display("FAIL power_up_counts got=%0d/%0d/%0d exp=4/2/1", n_len, n_sw, n_env);
        end
    endtask

    task automatic test_rates();
        power_cycle();
        run_check(512 * D, 1'b1);
        total++;
        if (n_len != 256 || n_sw != 128 || n_env != 64) begin
            bad++;
            $display("FAIL rates got=%0d/%0d/%0d exp=256/128/64", n_len, n_sw, n_env);
        end
    endtask

    task automatic test_power_drop();
        power_cycle();
        run_check(6 * D - 1, 1'b0);
        apu_on = 1'b0;
        run_check(1, 1'b0);
        total++;
        if ({clk_length_ctr, clk_sweep, clk_envelope} !== 3'b000 || step !== 3'd0) begin
            bad++;
            $display("FAIL power_drop got strb=%b step=%0d exp strb=000 step=0", {clk_length_ctr, clk_sweep, clk_envelope}, step);
        end
        run_check(3, 1'b0);
        apu_on = 1'b1;
        clear_counts();
        run_check(D, 1'b0);
        total++;
        if (n_len != 1 || clk_length_ctr !== 1'b1 || step !== 3'd1) begin
            bad++;
            $display("FAIL re_enable got len=%0d strb=%b step=%0d exp len=1 strb=1 step=1", n_len, clk_length_ctr, step);
        end
    endtask

    task automatic test_triggers();
        trig_wr = 4'b1011; dac_en = 4'b0011;
        run_check(1, 1'b0);
        total++;
        if (start !== 4'b0011) begin
            bad++;
            $display("FAIL trig_on got=%b exp=0011", start);
        end
        trig_wr = 4'b0000;
        run_check(1, 1'b0);
        total++;
        if (start !== 4'b0000) begin
            bad++;
            $display("FAIL trig_width got=%b exp=0000", start);
        end
        apu_on = 1'b0;
        run_check(2, 1'b0);
        trig_wr = 4'b1011;
        run_check(1, 1'b0);
        trig_wr = 4'b0000;
        total++;
        if (start !== 4'b0000) begin
            bad++;
            $display("FAIL trig_off got=%b exp=0000", start);
        end
    endtask

    task automatic test_coincidence();
        power_cycle();
        run_check(3 * D - 1, 1'b0);
        trig_wr = 4'b0001; dac_en = 4'b0001;
        run_check(1, 1'b0);
        trig_wr = 4'b0000;
        total++;
        if ({start[0], clk_length_ctr, clk_sweep} !== 3'b111) begin
            bad++;
            $display("FAIL coincidence got=%b exp=111", {start[0], clk_length_ctr, clk_sweep});
        end
    endtask

    task automatic test_mid_reset();
        power_cycle();
        run_check(5 * D + 3, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({clk_length_ctr, clk_sweep, clk_envelope, start, step, len_next_skip} !== 11'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=0", {clk_length_ctr, clk_sweep, clk_envelope, start, step, len_next_skip});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        trig_wr = 4'b0000;
        j = 0;
        run_check(2 * D + 1, 1'b1);
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_power_up();
        test_triggers();
        test_rates();
        test_power_drop();
        test_coincidence();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sound_frame_seq.md
Name: sound_frame_seq

Overview:
- APU frame sequencer and trigger scheduler for all four sound channels.
- Divides the system clock down to a 512 Hz event and steps an 8-step sequence.
- Issues one-cycle strobes to three consumers:
  - length tick to every sound_length_ctr instance (via the instances' clk_length_ctr input);
  - 128 Hz sweep tick to channel 1;
  - 64 Hz envelope tick to channels 1, 2 and 4.
- Qualifies NRx4 trigger writes into per-channel start pulses, gated by DAC enable and APU power.

Parameters:
- CLK_DIV, 8192, system clocks per 512 Hz event (4.194304 MHz / 8192).
- DIV_WIDTH, 13, prescaler width; must satisfy 2^DIV_WIDTH >= CLK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- apu_on  in  1  NR52 bit 7 (master power).
- trig_wr  in  4  one-cycle pulses, write to NRx4 with bit 7 set; bit i = channel i+1.
- dac_en  in  4  per-channel DAC enable.
- div_bit  in  1  external DIV tap; used only with SOUND_EXT_DIV_EN, otherwise ignored.
- clk_length_ctr  out  1  256 Hz length strobe.
- clk_sweep  out  1  128 Hz sweep strobe.
- clk_envelope  out  1  64 Hz envelope strobe.
- start  out  4  per-channel start pulse.
- step  out  3  index of the next step to execute.
- len_next_skip  out  1  high when the next step does not clock length (for the length-enable extra-clock quirk).

Behaviour:
- Reset (rst low, async): prescaler = 0, step = 0, and all strobes, start, len_next_skip and edge registers = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while apu_on = 1, then wraps to 0.
  - The 512 Hz event (evt) fires in the cycle the count equals CLK_DIV-1.
- Step table, applied when evt fires; step then increments, wrapping 7 -> 0:
  - step 0: length
  - step 1: none
  - step 2: length + sweep
  - step 3: none
  - step 4: length
  - step 5: none
  - step 6: length + sweep
  - step 7: envelope
- Strobe timing:
  - Strobes are registered: high for exactly one clk, the cycle after evt.
  - No strobe is ever wider than one cycle; never two strobes of the same kind in consecutive cycles.
- len_next_skip:
  - Combinational, equals step[0].
  - High when the next step is 1, 3, 5 or 7.
- Power off (apu_on = 0):
  - Synchronously clear the prescaler and set step = 0.
  - Strobes are forced 0, including a strobe scheduled in that same cycle; start is forced 0.
- Power on (0 -> 1):
  - Prescaler starts at 0.
  - The first evt occurs CLK_DIV cycles later and executes step 0.
- Trigger qualification:
  - start[i] is registered = trig_wr[i] & dac_en[i] & apu_on; latency 1 cycle, width 1 cycle.
  - A trigger with dac_en[i] = 0 produces no start.
  - A trigger coincident with a length strobe still issues start in the same cycle as that strobe. The length counter gives start priority; no arbitration is done here.
  - Multiple channels may start in the same cycle.
- Reset mid-sequence: outputs clear immediately (async); resumes as power-on once rst is released.

Optional Feature:
- Macro: SOUND_EXT_DIV_EN.
- Defined:
  - The internal prescaler is removed (CLK_DIV/DIV_WIDTH unused).
  - div_bit is registered twice for synchronisation; evt = synchronised falling edge of div_bit, while apu_on = 1.
  - The edge history resets to 0 on async reset and while apu_on = 0, so no spurious event occurs at power-on.
- Undefined: div_bit is ignored and the internal prescaler is used.

Test Plan:
- Reset and power-up: release rst, raise apu_on, run 8 × CLK_DIV cycles.
  - Length strobes at evts 1, 3, 5, 7; sweep at evts 3, 7; envelope at evt 8.
  - Every strobe is exactly 1 cycle wide, one cycle after its evt.
- Rates over 8192 × 512 cycles (1 s): exactly 256 length, 128 sweep and 64 envelope strobes.
- Power drop mid-sequence:
  - Drop apu_on at step 5, cycle CLK_DIV-1 -> no strobe, step reads 0.
  - After re-enable, the first evt occurs CLK_DIV cycles later and gives a length strobe (step 0).
- Triggers: trig_wr = 4'b1011, dac_en = 4'b0011 -> start = 4'b0011 next cycle for 1 cycle.
  - Same stimulus with apu_on = 0 -> start stays 0.
- Coincidence: trig_wr[0] in the evt cycle of step 2 -> start[0], clk_length_ctr and clk_sweep all high in the same following cycle.
- len_next_skip: reads 0 after reset; toggles each evt (1, 0, 1, ...) in step with step[0].
- SOUND_EXT_DIV_EN build: toggle div_bit with a period of 64 clk -> one evt per falling edge, with strobes 3 clk after the edge (2-stage sync + register).
  - A div_bit falling edge while apu_on = 0 produces nothing.
